// File: rtl/aes_top_pack.sv
// Shared constants and types for the word generator/checker family.
// Error-vector layout, checker FSM states and a length-check helper.
package aes_top_pack;

  localparam int WORD_COUNTER_SIZE = 8;

  localparam int ERR_W     = 5;
  localparam int ERR_LEN   = 0;
  localparam int ERR_SOP   = 1;
  localparam int ERR_EMPTY = 2;
  localparam int ERR_DATA  = 3;
  localparam int ERR_OVF   = 4;

  typedef enum logic {
    IDLE,
    IN_MSG
  } word_checker_state_e;

  function automatic logic len_mismatch(
    input logic                         en,
    input logic [WORD_COUNTER_SIZE-1:0] len,
    input logic [WORD_COUNTER_SIZE-1:0] exp_len
  );
    return en && (len != exp_len);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST word stream bundle with framing and byte-empty count.
// Master drives the beat; slave returns ready.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
);
  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; value updates on the edge after i_inc.
// Adds i_inc per cycle and sticks at all-ones, never wrapping; no backpressure.
module sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic [INC_WIDTH-1:0] i_inc,
  output logic [WIDTH-1:0]     o_cnt
);
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_cnt} + (WIDTH+1)'(i_inc);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (w_sum[WIDTH]) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_sum[WIDTH-1:0];
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/word_checker.sv
// Avalon-ST sink checking message framing, length and content; closures reported one cycle after
// the closing transfer. Ready follows sink_en only, so the sink never throttles the stream itself.
module word_checker
  import aes_top_pack::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter bit CHECK_ZERO_DATA = 1'b1,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  avalon_st_if.slave                   msg_in,
  input  logic                         sink_en,
  input  logic                         check_en,
  input  logic [WORD_COUNTER_SIZE-1:0] exp_word_cnt,
  output logic                         msg_done,
  output logic [WORD_COUNTER_SIZE-1:0] msg_len,
  output logic [ERR_W-1:0]             msg_err,
  output logic                         stray_err,
  output logic [STAT_WIDTH-1:0]        msg_total,
  output logic [STAT_WIDTH-1:0]        err_total
);
  typedef logic [WORD_COUNTER_SIZE-1:0] cnt_t;
  typedef logic [ERR_W-1:0]             err_t;

  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t CNT_MAX    = '1;
  localparam err_t LEN_MASK   = err_t'(1 << ERR_LEN);
  localparam err_t SOP_MASK   = err_t'(1 << ERR_SOP);
  localparam err_t EMPTY_MASK = err_t'(1 << ERR_EMPTY);
  localparam err_t DATA_MASK  = err_t'(1 << ERR_DATA);
  localparam err_t OVF_MASK   = err_t'(1 << ERR_OVF);

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_xfer;
  err_t                  w_beat_err;
  logic                  w_at_max;
  cnt_t                  w_len_inc;

  word_checker_state_e r_state, w_state_nxt;
  cnt_t                r_cnt, w_cnt_nxt;
  cnt_t                r_exp, w_exp_nxt;
  err_t                r_acc, w_acc_nxt;

  logic w_new_vld, w_sec_vld, w_stray;
  cnt_t w_new_len;
  err_t w_new_err, w_sec_err;

  logic r_pend_vld;
  cnt_t r_pend_len;
  err_t r_pend_err;

  logic r_done, r_stray;
  cnt_t r_len;
  err_t r_err;

  logic       w_close, w_close_err;
  logic [1:0] w_err_inc;

  assign msg_in.ready = sink_en & ~rst;
  assign w_data       = msg_in.data;
  assign w_xfer       = msg_in.valid & msg_in.ready;
  assign w_at_max     = (r_cnt == CNT_MAX);
  assign w_len_inc    = w_at_max ? CNT_MAX : r_cnt + CNT_ONE;

  // empty is only meaningful on the last beat of a message
  assign w_beat_err = ((~msg_in.eop & (|msg_in.empty)) ? EMPTY_MASK : '0)
                    | ((CHECK_ZERO_DATA && (|w_data)) ? DATA_MASK : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_exp_nxt   = r_exp;
    w_acc_nxt   = r_acc;
    w_new_vld   = 1'b0;
    w_new_len   = '0;
    w_new_err   = '0;
    w_sec_vld   = 1'b0;
    w_sec_err   = '0;
    w_stray     = 1'b0;
    if (w_xfer) begin
      case (r_state)
        IDLE: begin
          if (msg_in.sop && msg_in.eop) begin
            w_new_vld = 1'b1;
            w_new_len = CNT_ONE;
            w_new_err = w_beat_err
                      | (len_mismatch(check_en, CNT_ONE, exp_word_cnt) ? LEN_MASK : '0);
          end else if (msg_in.sop) begin
            w_cnt_nxt   = CNT_ONE;
            w_exp_nxt   = exp_word_cnt;
            w_acc_nxt   = w_beat_err;
            w_state_nxt = IN_MSG;
          end else begin
            w_stray = 1'b1;
          end
        end
        IN_MSG: begin
          if (msg_in.sop) begin
            w_new_vld = 1'b1;
            w_new_len = r_cnt;
            w_new_err = r_acc | SOP_MASK
                      | (len_mismatch(check_en, r_cnt, r_exp) ? LEN_MASK : '0);
            if (msg_in.eop) begin
              // the 1-word message that cut this one short is parked in the pending slot
              w_sec_vld   = 1'b1;
              w_sec_err   = w_beat_err
                          | (len_mismatch(check_en, CNT_ONE, exp_word_cnt) ? LEN_MASK : '0);
              w_cnt_nxt   = '0;
              w_acc_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = CNT_ONE;
              w_exp_nxt = exp_word_cnt;
              w_acc_nxt = w_beat_err;
            end
          end else if (msg_in.eop) begin
            w_new_vld   = 1'b1;
            w_new_len   = w_len_inc;
            w_new_err   = r_acc | w_beat_err | (w_at_max ? OVF_MASK : '0)
                        | (len_mismatch(check_en, w_len_inc, r_exp) ? LEN_MASK : '0);
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_len_inc;
            w_acc_nxt = r_acc | w_beat_err | (w_at_max ? OVF_MASK : '0);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A pending closure always drains first; it only exists while the FSM sits in IDLE,
  // where a transfer can create at most one new closure to queue behind it.
  assign w_close     = r_pend_vld | w_new_vld;
  assign w_close_err = r_pend_vld ? (|r_pend_err) : (|w_new_err);
  assign w_err_inc   = {1'b0, w_close & w_close_err} + {1'b0, w_stray};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_acc      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_len <= '0;
      r_pend_err <= '0;
      r_done     <= 1'b0;
      r_len      <= '0;
      r_err      <= '0;
      r_stray    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_exp   <= w_exp_nxt;
      r_acc   <= w_acc_nxt;
      r_stray <= w_stray;
      r_done  <= w_close;
      if (r_pend_vld) begin
        r_len      <= r_pend_len;
        r_err      <= r_pend_err;
        r_pend_vld <= w_new_vld;
        r_pend_len <= w_new_len;
        r_pend_err <= w_new_err;
      end else if (w_new_vld) begin
        r_len      <= w_new_len;
        r_err      <= w_new_err;
        r_pend_vld <= w_sec_vld;
        r_pend_len <= CNT_ONE;
        r_pend_err <= w_sec_err;
      end
    end
  end

  sat_counter #(.WIDTH(STAT_WIDTH), .INC_WIDTH(1)) u_msg_total (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_close),
    .o_cnt (msg_total)
  );

  sat_counter #(.WIDTH(STAT_WIDTH), .INC_WIDTH(2)) u_err_total (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_err_inc),
    .o_cnt (err_total)
  );

  assign msg_done  = r_done;
  assign msg_len   = r_len;
  assign msg_err   = r_err;
  assign stray_err = r_stray;
endmodule

// File: tb/tb_word_checker.sv
// Directed bench for word_checker: message-level reference model compared every cycle,
// plus hand-computed checkpoints after each scenario.
module tb_word_checker;
  import aes_top_pack::*;

  localparam int STAT_W = 4;            // small so total saturation is reachable
  localparam int SMAX   = (1 << STAT_W) - 1;
  localparam int CMAX   = (1 << WORD_COUNTER_SIZE) - 1;

  typedef struct packed {
    logic [WORD_COUNTER_SIZE-1:0] len;
    logic [ERR_W-1:0]             err;
  } clos_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sink_en = 1'b0;
  logic check_en = 1'b0;
  logic [WORD_COUNTER_SIZE-1:0] exp_word_cnt = '0;
  logic msg_done, stray_err;
  logic [WORD_COUNTER_SIZE-1:0] msg_len;
  logic [ERR_W-1:0] msg_err;
  logic [STAT_W-1:0] msg_total, err_total;

  avalon_st_if #(.DATA_WIDTH(128)) bus ();

  word_checker #(.DATA_WIDTH(128), .CHECK_ZERO_DATA(1'b1), .STAT_WIDTH(STAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .msg_in       (bus),
    .sink_en      (sink_en),
    .check_en     (check_en),
    .exp_word_cnt (exp_word_cnt),
    .msg_done     (msg_done),
    .msg_len      (msg_len),
    .msg_err      (msg_err),
    .stray_err    (stray_err),
    .msg_total    (msg_total),
    .err_total    (err_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;
  bit tog_mode = 0;
  int tog_idx  = 0;
  bit tog_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  clos_t q[$];
  bit    m_in_msg = 0;
  int    m_words  = 0;
  logic [ERR_W-1:0] m_errs = '0;
  logic [WORD_COUNTER_SIZE-1:0] m_exp = '0;
  bit    m_done = 0, m_stray = 0;
  logic [WORD_COUNTER_SIZE-1:0] m_len = '0;
  logic [ERR_W-1:0] m_err = '0;
  int    m_msg_tot = 0, m_err_tot = 0;

  function automatic void close_msg(input int words, input logic [ERR_W-1:0] e,
                                    input logic [WORD_COUNTER_SIZE-1:0] ex);
    clos_t c;
    c.len = (words > CMAX) ? WORD_COUNTER_SIZE'(CMAX) : WORD_COUNTER_SIZE'(words);
    if (words > CMAX) e[ERR_OVF] = 1'b1;
    if (check_en && c.len != ex) e[ERR_LEN] = 1'b1;
    c.err = e;
    q.push_back(c);
  endfunction

  always @(posedge clk) begin
    bit xfer;
    bit stray_now;
    logic [ERR_W-1:0] berr;
    clos_t c;
    if (rst) begin
      q.delete();
      m_in_msg = 0; m_words = 0; m_errs = '0; m_exp = '0;
      m_done = 0; m_stray = 0; m_len = '0; m_err = '0;
      m_msg_tot = 0; m_err_tot = 0;
    end else begin
      stray_now = 0;
      xfer = bus.valid && sink_en;
      if (xfer) begin
        berr = '0;
        if (bus.empty != 0 && !bus.eop) berr[ERR_EMPTY] = 1'b1;
        if (bus.data != 0) berr[ERR_DATA] = 1'b1;
        if (!bus.sop && !m_in_msg) begin
          stray_now = 1;
        end else begin
          if (bus.sop && m_in_msg) close_msg(m_words, m_errs | (ERR_W'(1) << ERR_SOP), m_exp);
          if (bus.sop) begin
            m_words = 0; m_errs = '0; m_exp = exp_word_cnt;
          end
          m_words++;
          m_errs |= berr;
          m_in_msg = 1;
          if (bus.eop) begin
            close_msg(m_words, m_errs, m_exp);
            m_in_msg = 0;
          end
        end
      end
      m_done = 0;
      m_stray = stray_now;
      if (q.size() > 0) begin
        c = q.pop_front();
        m_done = 1; m_len = c.len; m_err = c.err;
        if (m_msg_tot < SMAX) m_msg_tot++;
        if (c.err != 0 && m_err_tot < SMAX) m_err_tot++;
      end
      if (stray_now && m_err_tot < SMAX) m_err_tot++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",     32'(bus.ready), 32'(sink_en & ~rst));
      chk("msg_done",  32'(msg_done),  32'(m_done));
      chk("msg_len",   32'(msg_len),   32'(m_len));
      chk("msg_err",   32'(msg_err),   32'(m_err));
      chk("stray_err", 32'(stray_err), 32'(m_stray));
      chk("msg_total", 32'(msg_total), 32'(m_msg_tot));
      chk("err_total", 32'(err_total), 32'(m_err_tot));
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic s, input logic e, input logic [127:0] d, input logic [3:0] emp);
    int  guard;
    bit  taken;
    guard = 0;
    taken = 0;
    bus.valid = 1'b1; bus.sop = s; bus.eop = e; bus.data = d; bus.empty = emp;
    while (!taken) begin
      if (tog_mode) begin
        sink_en = tog_pat[tog_idx % 4];
        tog_idx++;
      end
      @(posedge clk);
      taken = sink_en && !rst;
      @(negedge clk);
      guard++;
      if (!taken && guard > 20) begin
        n_fail++;
        $display("FAIL beat_timeout: got no transfer, expected one within 20 cycles");
        taken = 1;
      end
    end
    bus.valid = 1'b0;
  endtask

  task automatic msg(input int n);
    for (int i = 0; i < n; i++) beat(i == 0, i == n - 1, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.data = '0; bus.empty = '0;
    sink_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1;
    chk("rst_done", 32'(msg_done), 32'd0);
    chk("rst_total", 32'(msg_total), 32'd0);

    // 1: plain 4-word message
    exp_word_cnt = 8'd4; check_en = 1'b1;
    msg(4);
    chk("t1_done", 32'(msg_done), 32'd1);
    chk("t1_len", 32'(msg_len), 32'd4);
    chk("t1_err", 32'(msg_err), 32'd0);
    chk("t1_tot", 32'(msg_total), 32'd1);
    chk("t1_etot", 32'(err_total), 32'd0);
    @(negedge clk);
    chk("t1_pulse", 32'(msg_done), 32'd0);

    // 2: same message under toggling backpressure
    tog_mode = 1; tog_idx = 0;
    msg(4);
    tog_mode = 0; sink_en = 1'b1;
    chk("t2_done", 32'(msg_done), 32'd1);
    chk("t2_len", 32'(msg_len), 32'd4);
    chk("t2_err", 32'(msg_err), 32'd0);

    // 3: length mismatch, then same with checking disabled
    exp_word_cnt = 8'd3;
    msg(5);
    chk("t3_len", 32'(msg_len), 32'd5);
    chk("t3_err", 32'(msg_err), 32'h01);
    chk("t3_etot", 32'(err_total), 32'd1);
    check_en = 1'b0;
    msg(5);
    chk("t3b_err", 32'(msg_err), 32'd0);

    // 4: message cut short by a sop&eop beat
    beat(1, 0, '0, '0);
    beat(0, 0, '0, '0);
    beat(1, 1, '0, '0);
    chk("t4a_done", 32'(msg_done), 32'd1);
    chk("t4a_len", 32'(msg_len), 32'd2);
    chk("t4a_err", 32'(msg_err), 32'h02);
    @(negedge clk);
    chk("t4b_done", 32'(msg_done), 32'd1);
    chk("t4b_len", 32'(msg_len), 32'd1);
    chk("t4b_err", 32'(msg_err), 32'd0);
    chk("t4_tot", 32'(msg_total), 32'd6);
    chk("t4_etot", 32'(err_total), 32'd2);

    // 5: stray beat, then nonzero data
    do_reset();
    beat(0, 0, '0, '0);
    chk("t5_stray", 32'(stray_err), 32'd1);
    beat(1, 1, 128'd1, '0);
    chk("t5_err", 32'(msg_err), 32'h08);
    chk("t5_etot", 32'(err_total), 32'd2);

    // 6: reset in the middle of a 6-word message
    exp_word_cnt = 8'd6; check_en = 1'b1;
    beat(1, 0, '0, '0);
    beat(0, 0, '0, '0);
    bus.valid = 1'b1; bus.sop = 1'b0; bus.eop = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.valid = 1'b0;
    chk("t6_rst_done", 32'(msg_done), 32'd0);
    chk("t6_rst_len", 32'(msg_len), 32'd0);
    chk("t6_rst_etot", 32'(err_total), 32'd0);
    chk("t6_rst_tot", 32'(msg_total), 32'd0);
    exp_word_cnt = 8'd3;
    msg(3);
    chk("t6_len", 32'(msg_len), 32'd3);
    chk("t6_err", 32'(msg_err), 32'd0);
    chk("t6_tot", 32'(msg_total), 32'd1);

    // expected count of zero never matches
    exp_word_cnt = 8'd0;
    beat(1, 1, '0, '0);
    chk("exp0_err", 32'(msg_err), 32'h01);

    // back-to-back single-word messages
    exp_word_cnt = 8'd1;
    beat(1, 1, '0, '0);
    chk("b2b_1", 32'(msg_done), 32'd1);
    beat(1, 1, '0, '0);
    chk("b2b_2", 32'(msg_done), 32'd1);
    chk("b2b_err", 32'(msg_err), 32'd0);

    // empty flagged on a middle beat only
    exp_word_cnt = 8'd2;
    beat(1, 0, '0, 4'd3);
    beat(0, 1, '0, 4'd5);
    chk("empty_err", 32'(msg_err), 32'h04);
    chk("empty_len", 32'(msg_len), 32'd2);

    // pending closure drains in the same cycle as a stray beat
    check_en = 1'b0;
    beat(1, 0, '0, '0);
    beat(1, 1, '0, '0);
    beat(0, 0, '0, '0);
    chk("pend_stray", 32'(stray_err), 32'd1);
    chk("pend_done", 32'(msg_done), 32'd1);
    chk("pend_len", 32'(msg_len), 32'd1);
    chk("pend_etot", 32'(err_total), 32'd4);
    chk("pend_tot", 32'(msg_total), 32'd7);

    // counter overflow: 256 words
    msg(256);
    chk("ovf_len", 32'(msg_len), 32'hFF);
    chk("ovf_err", 32'(msg_err), 32'h10);

    // totals saturate
    check_en = 1'b1; exp_word_cnt = 8'd0;
    repeat (16) beat(1, 1, '0, '0);
    @(negedge clk);
    chk("sat_tot", 32'(msg_total), 32'(SMAX));
    chk("sat_etot", 32'(err_total), 32'(SMAX));

    @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
